// File: rtl/serial_frame_sequencer_pkg.sv
// Shared definitions for the serial frame sequencer and the downstream capture demux.
package serial_frame_sequencer_pkg;

    localparam int unsigned      SEL_W            = 5;
    localparam logic [SEL_W-1:0] IDLE_SEL_DEFAULT = 5'd31;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } sfs_state_e;

endpackage

// File: rtl/strobe_timeout.sv
// Counts strobe-free cycles while a frame is open; flags expiry on the TIMEOUT-th quiet cycle.
module strobe_timeout #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_strobe,
    output logic o_expired
);
    localparam int unsigned    CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // A strobe landing on the last allowed cycle keeps the frame alive.
    assign o_expired = i_active & ~i_strobe & (r_count == LAST);

    always_ff @(posedge clk) begin
        if (reset || !i_active || i_strobe || o_expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_sequencer.sv
// Receives start/data/parity/stop strobes and emits each data bit with its index for the demux.
module serial_frame_sequencer
    import serial_frame_sequencer_pkg::*;
#(
    parameter int unsigned      FRAME_LEN = 20,
    parameter logic [SEL_W-1:0] IDLE_SEL  = IDLE_SEL_DEFAULT,
    parameter int unsigned      TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    output logic             data_out,
    output logic [SEL_W-1:0] sel,
    output logic             frame_done,
    output logic             frame_err,
    output logic [7:0]       err_count
);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(FRAME_LEN - 1);

    sfs_state_e       r_state, w_state_next;
    logic [SEL_W-1:0] r_idx, w_idx_next;
    logic [SEL_W-1:0] r_sel, w_sel_next;
    logic             r_par, w_par_next;
    logic             r_par_err, w_par_err_next;
    logic             r_data, w_data_next;
    logic             r_done, w_done_next;
    logic             r_err, w_err_next;
    logic [7:0]       r_err_count;
    logic             w_start, w_active, w_timeout;

    // A start coinciding with the frame_done pulse is deliberately dropped.
    assign w_start  = bit_valid & ~serial_in & ~r_done;
    assign w_active = (r_state != StIdle);

    strobe_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_active (w_active),
        .i_strobe (bit_valid),
        .o_expired(w_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_sel       <= IDLE_SEL;
            r_par       <= 1'b0;
            r_par_err   <= 1'b0;
            r_data      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_sel     <= w_sel_next;
            r_par     <= w_par_next;
            r_par_err <= w_par_err_next;
            r_data    <= w_data_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
            if (w_err_next && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:   if (w_start) w_state_next = StData;
                StData:   if (bit_valid && (r_idx == IDX_LAST)) w_state_next = StParity;
                StParity: if (bit_valid) w_state_next = StStop;
                StStop:   if (bit_valid) w_state_next = StIdle;
                default:  w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_idx_next     = r_idx;
        w_par_next     = r_par;
        w_par_err_next = r_par_err;
        w_data_next    = r_data;
        w_sel_next     = IDLE_SEL;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_idx_next     = '0;
                    w_par_next     = 1'b0;
                    w_par_err_next = 1'b0;
                end
            end
            StData: begin
                if (bit_valid) begin
                    w_data_next = serial_in;
                    w_sel_next  = r_idx;
                    w_idx_next  = r_idx + SEL_W'(1);
                    w_par_next  = r_par ^ serial_in;
                end
            end
            StParity: begin
                if (bit_valid) w_par_err_next = (serial_in != r_par);
            end
            StStop: begin
                if (bit_valid) begin
                    w_done_next = 1'b1;
                    w_err_next  = r_par_err | ~serial_in;
                end
            end
            default: ;
        endcase
        if (w_timeout) w_err_next = 1'b1;
    end

    assign data_out   = r_data;
    assign sel        = r_sel;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Randomized frame-level bench for serial_frame_sequencer against a behavioural frame model.
module tb_serial_frame_sequencer;

    localparam int          FL   = 20;
    localparam int          TO   = 64;
    localparam logic [4:0]  ISEL = 5'd31;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       bit_valid;
    logic       data_out;
    logic [4:0] sel;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // Model state: last presented data bit and expected errored-frame count.
    logic       m_data;
    logic [7:0] m_cnt;

    logic [15:0] obs;
    assign obs = {sel, data_out, frame_done, frame_err, err_count};

    always #5 clk = ~clk;

    serial_frame_sequencer #(
        .FRAME_LEN(FL),
        .IDLE_SEL (ISEL),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .bit_valid (bit_valid),
        .data_out  (data_out),
        .sel       (sel),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    task automatic step(input logic v, input logic s);
        bit_valid = v;
        serial_in = s;
        @(posedge clk);
        #1;
    endtask

    // Strobe j: 0 = start, 1..FL = data bits, FL+1 = parity, FL+2 = stop.
    task automatic send_frame(input logic [29:0] data, input logic par_flip, input logic stop_bit,
                              input int max_gap, input string tag);
        logic        par;
        logic        bad;
        logic        sv;
        logic [15:0] exp;
        int          n;
        par = ^data[FL-1:0];
        for (int j = 0; j <= FL + 2; j++) begin
            n = (j == 0) ? 1 + $urandom_range(0, 2) : $urandom_range(0, max_gap);
            for (int k = 0; k < n; k++) begin
                if (j == 0) step(1'($urandom_range(0, 1)), 1'b1);
                else        step(1'b0, 1'($urandom));
                exp = {ISEL, m_data, 2'b00, m_cnt};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s gap%0d: got %h want %h (sel,data,done,err,cnt)",
                             tag, j, obs, exp);
                end
            end
            if (j == 0)            sv = 1'b0;
            else if (j <= FL)      sv = data[j-1];
            else if (j == FL + 1)  sv = par ^ par_flip;
            else                   sv = stop_bit;
            step(1'b1, sv);
            if (j >= 1 && j <= FL) begin
                m_data = sv;
                exp = {5'(j - 1), m_data, 2'b00, m_cnt};
            end else if (j == FL + 2) begin
                bad = par_flip | ~stop_bit;
                if (bad) m_cnt = sat_inc(m_cnt);
                exp = {ISEL, m_data, 1'b1, bad, m_cnt};
            end else begin
                exp = {ISEL, m_data, 2'b00, m_cnt};
            end
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s strobe%0d: got %h want %h (sel,data,done,err,cnt)",
                         tag, j, obs, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'($urandom), 1'($urandom));
            checks++;
            if (obs !== {ISEL, 1'b0, 2'b00, 8'd0}) begin
                errors++;
                $display("FAIL reset: got %h want %h", obs, {ISEL, 1'b0, 2'b00, 8'd0});
            end
        end
        reset = 1'b0;
        m_data = 1'b0;
        m_cnt  = 8'd0;
    endtask

    task automatic test_clean_frame();
        send_frame(30'h0A5A5, 1'b0, 1'b1, 0, "clean_a5a5");
        for (int k = 0; k < 4; k++) send_frame(30'($urandom), 1'b0, 1'b1, 4, "clean_rand");
    endtask

    task automatic test_parity_error();
        checks++;
        if (err_count !== m_cnt) begin
            errors++;
            $display("FAIL parity_pre_cnt: got %0d want %0d", err_count, m_cnt);
        end
        send_frame(30'($urandom), 1'b1, 1'b1, 2, "parity_err");
    endtask

    task automatic test_stop_error();
        send_frame(30'($urandom), 1'b0, 1'b0, 2, "stop_err");
    endtask

    task automatic test_timeout();
        logic        b;
        logic [15:0] exp;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            // Before bit 4 the strobe lands exactly TO cycles after the previous one.
            if (i == 4) begin
                for (int k = 0; k < TO - 1; k++) begin
                    step(1'b0, 1'($urandom));
                    checks++;
                    if (obs !== {ISEL, m_data, 2'b00, m_cnt}) begin
                        errors++;
                        $display("FAIL timeout_edge_gap: got %h want %h", obs,
                                 {ISEL, m_data, 2'b00, m_cnt});
                    end
                end
            end
            b = 1'($urandom);
            step(1'b1, b);
            m_data = b;
            checks++;
            if (obs !== {5'(i), m_data, 2'b00, m_cnt}) begin
                errors++;
                $display("FAIL timeout_bit%0d: got %h want %h", i, obs,
                         {5'(i), m_data, 2'b00, m_cnt});
            end
        end
        for (int k = 0; k < TO - 1; k++) begin
            step(1'b0, 1'($urandom));
            checks++;
            if (frame_err !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early k=%0d: got err=%b done=%b want 0 0",
                         k, frame_err, frame_done);
            end
        end
        step(1'b0, 1'b1);
        m_cnt = sat_inc(m_cnt);
        exp = {ISEL, m_data, 1'b0, 1'b1, m_cnt};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL timeout_pulse: got %h want %h", obs, exp);
        end
        step(1'b0, 1'b1);
        checks++;
        if (obs !== {ISEL, m_data, 2'b00, m_cnt}) begin
            errors++;
            $display("FAIL timeout_after: got %h want %h", obs, {ISEL, m_data, 2'b00, m_cnt});
        end
        send_frame(30'($urandom), 1'b0, 1'b1, 1, "after_timeout");
    endtask

    task automatic test_reset_mid_frame();
        logic [29:0] d;
        d = 30'($urandom);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, d[i]);
            m_data = d[i];
            checks++;
            if (obs !== {5'(i), m_data, 2'b00, m_cnt}) begin
                errors++;
                $display("FAIL midreset_bit%0d: got %h want %h", i, obs,
                         {5'(i), m_data, 2'b00, m_cnt});
            end
        end
        reset = 1'b1;
        step(1'b1, d[10]);
        step(1'b1, 1'b0);
        m_data = 1'b0;
        m_cnt  = 8'd0;
        checks++;
        if (obs !== {ISEL, 1'b0, 2'b00, 8'd0}) begin
            errors++;
            $display("FAIL midreset_hold: got %h want %h", obs, {ISEL, 1'b0, 2'b00, 8'd0});
        end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'($urandom));
            checks++;
            if (obs !== {ISEL, 1'b0, 2'b00, 8'd0}) begin
                errors++;
                $display("FAIL midreset_quiet: got %h want %h", obs, {ISEL, 1'b0, 2'b00, 8'd0});
            end
        end
        send_frame(30'($urandom), 1'b0, 1'b1, 2, "after_reset");
    endtask

    task automatic test_back_to_back();
        send_frame(30'($urandom), 1'b0, 1'b1, 0, "b2b_first");
        // Start bit driven during the frame_done cycle must be ignored.
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {ISEL, m_data, 2'b00, m_cnt}) begin
            errors++;
            $display("FAIL b2b_start_on_done: got %h want %h", obs, {ISEL, m_data, 2'b00, m_cnt});
        end
        step(1'b1, 1'b1);
        checks++;
        if (obs !== {ISEL, m_data, 2'b00, m_cnt}) begin
            errors++;
            $display("FAIL b2b_still_idle: got %h want %h", obs, {ISEL, m_data, 2'b00, m_cnt});
        end
        send_frame(30'($urandom), 1'b0, 1'b1, 0, "b2b_second");
        send_frame(30'($urandom), 1'b1, 1'b0, 0, "b2b_third");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 300; k++) begin
            send_frame(30'($urandom), (k % 2) == 0, (k % 2) == 0, 0, "sat");
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation: got %0d want 255", err_count);
        end
        send_frame(30'($urandom), 1'b1, 1'b1, 1, "sat_hold");
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bit_valid = 1'b0;
        serial_in = 1'b1;
        m_data    = 1'b0;
        m_cnt     = 8'd0;
        test_reset();
        test_clean_frame();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_sequencer.md
SERIAL_FRAME_SEQUENCER -- requirements
Module: serial_frame_sequencer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 20, meaning the number of data bits per frame (legal range 1..30).
REQ-002 SHALL have parameter IDLE_SEL, default 31, meaning the sel value driven when no data bit is presented; must lie outside 0..FRAME_LEN-1.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning the maximum clk cycles allowed between bit_valid strobes inside a frame.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port serial_in, input, 1 bit: the line bit, idle high.
REQ-007 SHALL have port bit_valid, input, 1 bit: qualifies serial_in for one clk.
REQ-008 SHALL have port data_out, output, 1 bit: registered data bit for the downstream capture demux.
REQ-009 SHALL have port sel, output, 5 bits: registered bit index paired with data_out.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse marking the end of a frame.
REQ-011 SHALL have port frame_err, output, 1 bit: valid with frame_done, or pulsed alone on timeout.
REQ-012 SHALL have port err_count, output, 8 bits: saturating count of errored frames.

Function
REQ-013 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE SHALL advance to DATA on bit_valid with serial_in==0 (start bit), clearing idx to 0 and parity accumulator to 0; bit_valid with serial_in==1 SHALL keep IDLE.
REQ-015 In DATA, each bit_valid SHALL register data_out<=serial_in and sel<=idx one cycle later, then increment idx and XOR the bit into the parity accumulator.
REQ-016 DATA SHALL advance to PARITY on the strobe where idx==FRAME_LEN-1.
REQ-017 On the PARITY strobe, the block SHALL record a parity error if serial_in != accumulator (even parity), then advance to STOP.
REQ-018 On the STOP strobe, the block SHALL pulse frame_done for one cycle and set frame_err=1 if a parity error was recorded or serial_in==0, then return to IDLE.
REQ-019 On any cycle without an accepted data bit, sel SHALL be IDLE_SEL and data_out SHALL hold its last value.
REQ-020 Data-path latency SHALL be exactly 1 clk from the bit_valid cycle to data_out/sel.
REQ-021 The timeout counter SHALL reset on every strobe in DATA/PARITY/STOP; reaching TIMEOUT SHALL pulse frame_err without frame_done and return to IDLE.
REQ-022 err_count SHALL increment on each frame_err pulse and saturate at 255, never wrapping.
REQ-023 A start bit arriving in the same cycle as the frame_done pulse SHALL NOT be accepted; the first accepted start is on a later strobe in IDLE.
REQ-024 Cycles with bit_valid==0 SHALL NOT change state, idx or parity.

Reset
REQ-025 While reset is high, the block SHALL be in IDLE with sel=IDLE_SEL, data_out=0, frame_done=0, frame_err=0, err_count=0, idx=0 and the timeout counter at 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no frame_done or frame_err pulse.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-028 The state encoding, IDLE_SEL default and sel width (5) SHALL live in the shared package also used by the capture demux.
REQ-029 The timeout counter MAY be a sub-module named strobe_timeout; everything else SHALL be in one module.

Verification
REQ-030 Clean frame (FRAME_LEN=20): start, data 0xA5A5 with bits 16..19=0, correct parity, stop=1 -> sel steps 0..19 with matching data_out one cycle after each strobe, one frame_done, frame_err=0.
REQ-031 Wrong parity bit -> frame_done with frame_err=1, err_count 0->1.
REQ-032 Stop bit 0 -> frame_done with frame_err=1.
REQ-033 No strobe for 64 cycles after data bit 7 -> frame_err pulse, frame_done=0, state IDLE, sel=31.
REQ-034 Reset at data bit 10 -> no pulses, sel=31; the next frame is received correctly.
REQ-035 300 errored frames -> err_count=255.
